// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed multiply-accumulate engine for the FIR audio filter.
// One sample is captured per strobe into an N_TAPS-deep delay line. The
// engine then walks the tap index from N_TAPS-1 down to 0, one product per
// clock, and publishes one filtered result per sample.
// Optional build macro ROUND_SAT_EN: when defined, the accumulator is
// rounded (add 2^(COEF_W-2), arithmetic shift right by COEF_W-1) and
// saturated to the DATA_W range before it is loaded into result. When left
// undefined, result carries the raw full-precision accumulator.
module fir_mac_sequencer #(
    parameter int N_TAPS = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 35,
    parameter int IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_in,
    output logic [IDX_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     busy,
    output logic                     result_valid,
    output logic signed [ACC_W-1:0]  result,
    output logic                     overrun
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TAPS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_r;
    logic [IDX_W-1:0]           idx_r;
    logic signed [DATA_W-1:0]   x_r [N_TAPS];
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [ACC_W-1:0]    result_r;
    logic                       busy_r;
    logic                       result_valid_r;
    logic signed [PROD_W-1:0]   prod_s;
    logic signed [ACC_W-1:0]    acc_next_s;

`ifdef ROUND_SAT_EN
    localparam logic signed [ACC_W:0] ROUND_ADD = (ACC_W+1)'(2**(COEF_W-2));
    localparam logic signed [ACC_W:0] SAT_MAX   = (ACC_W+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN   = -((ACC_W+1)'(2**(DATA_W-1)));
`endif

    // Converts the final accumulator into the published result format.
    function automatic logic signed [ACC_W-1:0] fmt_result(input logic signed [ACC_W-1:0] a);
`ifdef ROUND_SAT_EN
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] sh;
        rnd = (ACC_W+1)'(a) + ROUND_ADD;
        sh  = rnd >>> (COEF_W - 1);
        if (sh > SAT_MAX) begin
            sh = SAT_MAX;
        end else if (sh < SAT_MIN) begin
            sh = SAT_MIN;
        end else begin
            sh = sh;
        end
        return ACC_W'(sh);
`else
        return a;
`endif
    endfunction

    // Product of the current tap and its coefficient, added to the running sum.
    always_comb begin
        prod_s     = PROD_W'(x_r[idx_r]) * PROD_W'(coef_data);
        acc_next_s = acc_r + ACC_W'(prod_s);
    end

    // Sequencer: sample capture, downward tap walk, result publication.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            idx_r          <= IDX_LAST;
            acc_r          <= '0;
            result_r       <= '0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                x_r[k] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    result_valid_r <= 1'b0;
                    idx_r          <= IDX_LAST;
                    if (sample_valid) begin
                        x_r[0] <= sample_in;
                        for (int k = 1; k < N_TAPS; k++) begin
                            x_r[k] <= x_r[k-1];
                        end
                        acc_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_MAC;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_next_s;
                    if (idx_r == '0) begin
                        // Last tap: the result is ready as DONE becomes visible.
                        result_r       <= fmt_result(acc_next_s);
                        result_valid_r <= 1'b1;
                        state_r        <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r - IDX_ONE;
                        state_r <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    result_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                    idx_r          <= IDX_LAST;
                    state_r        <= ST_IDLE;
                end
                default: begin
                    result_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                    idx_r          <= IDX_LAST;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    assign coef_addr    = idx_r;
    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign result       = result_r;
    // A strobe arriving while a sequence runs is flagged in the same cycle;
    // an active reset suppresses the flag.
    assign overrun      = sample_valid & busy_r & reset;

endmodule
